// File: rtl/risc_v_mike_mem_arbiter_if.sv
// Signal bundle between the core's IF/LS ports, the unified memory and the arbiter.
// Loader signals exist only when RISC_V_MIKE_ARB_LOADER_EN is defined.
interface risc_v_mike_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  ls_req;
    logic                  ls_we;
    logic [DATA_W/8-1:0]   ls_be;
    logic [ADDR_W-1:0]     ls_addr;
    logic [DATA_W-1:0]     ls_wdata;
    logic                  ls_gnt;
    logic                  ls_rvalid;
    logic [DATA_W-1:0]     ls_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

`ifdef RISC_V_MIKE_ARB_LOADER_EN
    logic                  ld_req;
    logic [ADDR_W-1:0]     ld_addr;
    logic [DATA_W-1:0]     ld_wdata;
    logic [DATA_W/8-1:0]   ld_be;
    logic                  ld_gnt;
    logic                  ld_rvalid;
`endif

    // Arbiter side
    modport slave (
`ifdef RISC_V_MIKE_ARB_LOADER_EN
        input  ld_req, ld_addr, ld_wdata, ld_be,
        output ld_gnt, ld_rvalid,
`endif
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester / memory side
    modport master (
`ifdef RISC_V_MIKE_ARB_LOADER_EN
        output ld_req, ld_addr, ld_wdata, ld_be,
        input  ld_gnt, ld_rvalid,
`endif
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/risc_v_mike_mem_arbiter.sv
// Single-port memory arbiter: LS over IF with a 2-grant fetch starvation guard.
// Optional highest-priority write-only loader port: define RISC_V_MIKE_ARB_LOADER_EN.
module risc_v_mike_mem_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    risc_v_mike_mem_arbiter_if.slave      io_bus
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
    typedef enum logic [1:0] {OwnIf, OwnLs, OwnLd} owner_e;

    state_e              r_state, w_state_next;
    owner_e              r_owner, w_owner_next;
    logic [CNT_W-1:0]    r_wait_cnt, w_wait_cnt_next;
    logic [1:0]          r_ls_streak, w_ls_streak_next;
    logic                r_mem_we, w_mem_we_next;
    logic [BE_W-1:0]     r_mem_be, w_mem_be_next;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_next;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_next;
    logic [DATA_W-1:0]   r_if_rdata, w_if_rdata_next;
    logic [DATA_W-1:0]   r_ls_rdata, w_ls_rdata_next;

    logic w_arb_en;
    logic w_ld_win;
    logic w_ls_win;
    logic w_if_win;
    logic w_grant;
    logic w_mem_en;
    logic w_rvalid;

    // Grants are gated by reset so a requester never sees a grant that is then dropped.
    assign w_arb_en = !i_rst && ((r_state == StIdle) || (r_state == StResp));

`ifdef RISC_V_MIKE_ARB_LOADER_EN
    assign w_ld_win = w_arb_en && io_bus.ld_req;
`else
    assign w_ld_win = 1'b0;
`endif

    assign w_ls_win = w_arb_en && !w_ld_win && io_bus.ls_req &&
                      !(io_bus.if_req && (r_ls_streak == 2'd2));
    assign w_if_win = w_arb_en && !w_ld_win && !w_ls_win && io_bus.if_req;
    assign w_grant  = w_ld_win || w_ls_win || w_if_win;

    always_comb begin
        w_state_next     = r_state;
        w_owner_next     = r_owner;
        w_wait_cnt_next  = r_wait_cnt;
        w_ls_streak_next = r_ls_streak;
        w_mem_we_next    = r_mem_we;
        w_mem_be_next    = r_mem_be;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_if_rdata_next  = r_if_rdata;
        w_ls_rdata_next  = r_ls_rdata;

        unique case (r_state)
            StIdle, StResp: begin
                if (w_grant) begin
                    w_state_next    = StAccess;
                    w_wait_cnt_next = CNT_LOAD;
                end else begin
                    w_state_next = StIdle;
                end
            end
            StAccess: begin
                if (r_wait_cnt == '0) begin
                    w_state_next = StResp;
                    if (!r_mem_we) begin
                        if (r_owner == OwnIf) begin
                            w_if_rdata_next = io_bus.mem_rdata;
                        end else if (r_owner == OwnLs) begin
                            w_ls_rdata_next = io_bus.mem_rdata;
                        end
                    end
                end else begin
                    w_wait_cnt_next = r_wait_cnt - CNT_W'(1);
                end
            end
            default: w_state_next = StIdle;
        endcase

        // Loader grants leave the streak alone; an idle fetch port clears it.
        if (w_if_win) begin
            w_ls_streak_next = 2'd0;
        end else if (w_ls_win) begin
            w_ls_streak_next = io_bus.if_req ? (r_ls_streak + 2'd1) : 2'd0;
        end else if (w_arb_en && !w_ld_win && !io_bus.if_req) begin
            w_ls_streak_next = 2'd0;
        end

`ifdef RISC_V_MIKE_ARB_LOADER_EN
        if (w_ld_win) begin
            w_owner_next     = OwnLd;
            w_mem_we_next    = 1'b1;
            w_mem_be_next    = io_bus.ld_be;
            w_mem_addr_next  = io_bus.ld_addr;
            w_mem_wdata_next = io_bus.ld_wdata;
        end
`endif
        if (w_ls_win) begin
            w_owner_next     = OwnLs;
            w_mem_we_next    = io_bus.ls_we;
            w_mem_be_next    = io_bus.ls_be;
            w_mem_addr_next  = io_bus.ls_addr;
            w_mem_wdata_next = io_bus.ls_wdata;
        end
        if (w_if_win) begin
            w_owner_next     = OwnIf;
            w_mem_we_next    = 1'b0;
            w_mem_be_next    = '1;
            w_mem_addr_next  = io_bus.if_addr;
            w_mem_wdata_next = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_owner     <= OwnIf;
            r_wait_cnt  <= '0;
            r_ls_streak <= 2'd0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_owner     <= w_owner_next;
            r_wait_cnt  <= w_wait_cnt_next;
            r_ls_streak <= w_ls_streak_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_be    <= w_mem_be_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_if_rdata  <= w_if_rdata_next;
            r_ls_rdata  <= w_ls_rdata_next;
        end
    end

    assign w_mem_en = (r_state == StAccess);
    assign w_rvalid = !i_rst && (r_state == StResp);

    assign io_bus.mem_en    = w_mem_en;
    assign io_bus.mem_we    = w_mem_en && r_mem_we;
    assign io_bus.mem_be    = w_mem_en ? r_mem_be : '0;
    assign io_bus.mem_addr  = w_mem_en ? r_mem_addr : '0;
    assign io_bus.mem_wdata = w_mem_en ? r_mem_wdata : '0;

    assign io_bus.if_gnt    = w_if_win;
    assign io_bus.if_rvalid = w_rvalid && (r_owner == OwnIf);
    assign io_bus.if_rdata  = r_if_rdata;

    assign io_bus.ls_gnt    = w_ls_win;
    assign io_bus.ls_rvalid = w_rvalid && (r_owner == OwnLs);
    assign io_bus.ls_rdata  = r_ls_rdata;

`ifdef RISC_V_MIKE_ARB_LOADER_EN
    assign io_bus.ld_gnt    = w_ld_win;
    assign io_bus.ld_rvalid = w_rvalid && (r_owner == OwnLd);
`endif
endmodule

// File: doc/risc_v_mike_mem_arbiter.md
# risc_v_mike_mem_arbiter

Shared-memory arbiter for the RISC-V core: multiplexes one single-port unified memory between the instruction-fetch (IF) port and the load/store (LS) port of the datapath. It sequences each access through a fixed-latency memory cycle, returns read data and write acknowledges to the winning requester, and prevents fetch starvation under back-to-back load/store traffic. It sits between the core datapath and the memory macro inside the top level.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width, multiple of 8
- WAIT_CYCLES, 1, memory access cycles, >= 1
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted (combinational, this cycle)
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- ls_req, ls_we  in  1 each  load/store request, write enable
- ls_be  in  DATA_W/8  byte enables (writes)
- ls_addr  in  ADDR_W; ls_wdata  in  DATA_W
- ls_gnt  out  1; ls_rvalid  out  1 (read data or write ack); ls_rdata  out  DATA_W
- mem_en, mem_we  out  1 each; mem_be  out  DATA_W/8; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W  valid in the last cycle of mem_en
- ld_* (req, addr, wdata, be, gnt, rvalid): present only with RISC_V_MIKE_ARB_LOADER_EN, write-only loader port

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req, pick winner, assert its gnt combinationally, register addr/we/be/wdata onto mem_*, go ACCESS. No req: stay IDLE, all gnt low.
- Priority: LS over IF, except starvation guard: 2-bit counter `ls_streak` counts consecutive LS grants while if_req is high; when it reaches 2, IF wins the next arbitration. Counter clears on any IF grant or when if_req low at arbitration.
- ACCESS: mem_en=1 for exactly WAIT_CYCLES cycles (internal down-counter); in final cycle capture mem_rdata into the winner's rdata register; go RESP.
- RESP: winner's rvalid=1 for one cycle; rdata holds until next rvalid for that port. RESP arbitrates like IDLE (back-to-back grant allowed) and goes ACCESS on grant, else IDLE.
- Writes: mem_we=1 with mem_en; rvalid still pulses as ack; rdata unchanged.
- mem_we/mem_be/mem_wdata forced 0 when mem_en=0. IF requests always reads (mem_we=0, mem_be all-ones).
- Requests are not abandoned: requester keeps req/addr stable until gnt; arbiter samples only at grant.

## Timing
- Reset: state IDLE, ls_streak=0, every output 0 (gnt, rvalid, rdata, mem_*).
- Grant in cycle N -> mem_en high N+1..N+WAIT_CYCLES -> rvalid in N+WAIT_CYCLES+1.
- Peak throughput: one access per WAIT_CYCLES+1 cycles.
- Simultaneous if_req and ls_req: LS granted unless ls_streak==2.
- rst during ACCESS/RESP: access aborted, mem_en low next cycle, no rvalid issued.
- Address wrap: none; mem_addr passed through unmodified.

## Configuration
- RISC_V_MIKE_ARB_LOADER_EN defined: third write-only loader port ld_* added with highest priority over LS and IF (excluded from starvation guard; loader grants do not change ls_streak); ld_rvalid acks writes with same latency.
- Undefined: ld_* ports and logic absent; two-requester arbiter as above.

## Test plan
- Single fetch, WAIT_CYCLES=1: if_req, if_addr=0x10, mem_rdata=0x00500093 -> if_gnt cycle N, mem_en N+1, if_rvalid N+2 with if_rdata=0x00500093.
- Store: ls_we=1, ls_be=4'b0011, ls_wdata=0xDEADBEEF, ls_addr=0x200 -> mem_we/mem_be=0011/mem_wdata=0xDEADBEEF in N+1, ls_rvalid N+2, ls_rdata unchanged.
- Simultaneous reqs held continuously -> grant order LS, LS, IF, LS, LS, IF; no requester waits more than 3 grants.
- WAIT_CYCLES=3, back-to-back LS reads -> mem_en high 3 cycles, ls_rvalid at N+4, next gnt in same RESP cycle.
- rst asserted in second ACCESS cycle -> all outputs 0 next cycle, no rvalid; fresh request served normally after release.
- With RISC_V_MIKE_ARB_LOADER_EN: ld_req, ls_req, if_req together -> loader first, then LS, then IF; ls_streak unaffected by loader grants.
